// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO frame serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        GAP_WAIT
    } state_t;

    localparam int FRAME_CNT_W = 16;

    function automatic int bit_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding register with a full flag; a write takes priority over a read.
module piso_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_wr) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer: shifts a word out on SI, then strobes latch.
// Optional build macro PISO_SKID_EN adds a one-word skid register for back-to-back frames.
module piso_frame_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   SI,
    output logic                   latch,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int               CNT_W    = bit_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [WIDTH-1:0]         r_sr;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic [3:0]               r_gap_cnt;
    logic                     r_si;
    logic                     r_latch;
    logic                     r_up;
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;

    logic                     w_accept;
    logic                     w_pending;
    logic                     w_load;
    logic [WIDTH-1:0]         w_load_word;
    logic                     w_load_first;
    logic [WIDTH-1:0]         w_load_rest;
    logic                     w_sr_first;
    logic [WIDTH-1:0]         w_sr_rest;

`ifdef PISO_SKID_EN
    logic                     w_hold_full;
    logic [WIDTH-1:0]         w_hold_data;
    logic                     w_hold_wr;
    logic                     w_hold_rd;

    assign in_ready    = r_up & ~w_hold_full;
    assign w_accept    = in_valid & in_ready;
    // Idle with an empty holder bypasses straight into the shifter; otherwise words queue here.
    assign w_hold_wr   = w_accept & (r_state != IDLE);
    assign w_hold_rd   = w_load & w_hold_full;
    assign w_pending   = w_hold_full | ((r_state == IDLE) & w_accept);
    assign w_load_word = w_hold_full ? w_hold_data : in_data;

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_wr   (w_hold_wr),
        .i_rd   (w_hold_rd),
        .i_data (in_data),
        .o_full (w_hold_full),
        .o_data (w_hold_data)
    );
`else
    assign in_ready    = r_up & (r_state == IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_pending   = w_accept;
    assign w_load_word = in_data;
`endif

    always_comb begin
        if (MSB_FIRST) begin
            w_load_first = w_load_word[WIDTH-1];
            w_load_rest  = {w_load_word[WIDTH-2:0], 1'b0};
            w_sr_first   = r_sr[WIDTH-1];
            w_sr_rest    = {r_sr[WIDTH-2:0], 1'b0};
        end else begin
            w_load_first = w_load_word[0];
            w_load_rest  = {1'b0, w_load_word[WIDTH-1:1]};
            w_sr_first   = r_sr[0];
            w_sr_rest    = {1'b0, r_sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (GAP > 0) begin
                    w_state_nxt = GAP_WAIT;
                end else if (w_pending) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GAP_WAIT: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (w_pending) begin
                        w_state_nxt = SHIFT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // SI is registered, so the first bit is driven on the load edge itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_si        <= 1'b0;
            r_latch     <= 1'b0;
            r_up        <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_up    <= 1'b1;
            r_si    <= 1'b0;
            r_latch <= 1'b0;
            if (w_load) begin
                r_si      <= w_load_first;
                r_sr      <= w_load_rest;
                r_bit_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == LAST_BIT) begin
                    r_latch     <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_si <= w_sr_first;
                    r_sr <= w_sr_rest;
                end
            end
            if (r_state == GAP_WAIT) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign SI        = r_si;
    assign latch     = r_latch;
    assign busy      = (r_state != IDLE);
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Scoreboarded bench: an MSB-first GAP=0 instance and an LSB-first GAP=3 instance,
// each followed by a modelled downstream shift register that captures on latch.
module tb_piso_frame_serializer;

`ifdef PISO_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int PERIOD_M = SKID ? 9 : 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data_m = '0, in_data_l = '0;
    logic        in_valid_m = 1'b0, in_valid_l = 1'b0;
    logic        in_ready_m, in_ready_l;
    logic        si_m, si_l, latch_m, latch_l, busy_m, busy_l;
    logic [15:0] cnt_m, cnt_l;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    int         lat_m[$];
    logic [7:0] po_m = '0, po_l = '0;
    logic       prev_latch_m = 1'b0, prev_latch_l = 1'b0;

    int a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_frame_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1),
        .GAP       (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data_m),
        .in_valid  (in_valid_m),
        .in_ready  (in_ready_m),
        .SI        (si_m),
        .latch     (latch_m),
        .busy      (busy_m),
        .frame_cnt (cnt_m)
    );

    piso_frame_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0),
        .GAP       (3)
    ) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data_l),
        .in_valid  (in_valid_l),
        .in_ready  (in_ready_l),
        .SI        (si_l),
        .latch     (latch_l),
        .busy      (busy_l),
        .frame_cnt (cnt_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Monitors: model downstream SIPO, compare its PO against the scoreboard on each latch.
    always @(negedge clk) begin
        if (!rst) begin
            po_m = '0;
            prev_latch_m = 1'b0;
        end else begin
            if (latch_m) begin
                chk("si_low_at_latch_m", si_m, 0);
                chk("latch_not_repeated_m", prev_latch_m, 0);
                if (q_m.size() == 0) timeout_fail("unexpected_latch_m");
                else chk("po_m", po_m, q_m.pop_front());
                lat_m.push_back(cyc);
            end else begin
                po_m = {po_m[6:0], si_m};
            end
            prev_latch_m = latch_m;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            po_l = '0;
            prev_latch_l = 1'b0;
        end else begin
            if (latch_l) begin
                chk("si_low_at_latch_l", si_l, 0);
                chk("latch_not_repeated_l", prev_latch_l, 0);
                if (q_l.size() == 0) timeout_fail("unexpected_latch_l");
                else chk("po_l", po_l, q_l.pop_front());
            end else begin
                po_l = {si_l, po_l[7:1]};
            end
            prev_latch_l = latch_l;
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input bit lsb, input logic [7:0] w, input bit keep);
        int n = 0;
        if (lsb) begin
            in_data_l = w; in_valid_l = 1'b1; q_l.push_back(w);
        end else begin
            in_data_m = w; in_valid_m = 1'b1; q_m.push_back(w);
        end
        while (!(lsb ? in_ready_l : in_ready_m)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                timeout_fail("accept_wait");
                break;
            end
        end
        @(negedge clk);
        if (!keep) begin
            if (lsb) in_valid_l = 1'b0;
            else     in_valid_m = 1'b0;
        end
    endtask

    task automatic wait_lat(input int n, input int budget);
        int k = 0;
        while (lat_m.size() < n) begin
            @(negedge clk);
            k++;
            if (k > budget) begin
                timeout_fail("latch_wait");
                break;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_in_ready", in_ready_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_si", si_m, 0);
        chk("rst_latch", latch_m, 0);
        chk("rst_frame_cnt", cnt_m, 0);
        rst = 1'b1;
        #1;
        chk("ready_before_first_edge", in_ready_m, 0);
        @(negedge clk);
        chk("ready_after_first_edge", in_ready_m, 1);

        // 8'hA5 MSB first: exact bit sequence, latency and count
        issue(1'b0, 8'hA5, 1'b0);
        chk("shift_busy", busy_m, 1);
        chk("shift_in_ready", in_ready_m, SKID);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_bit%0d", i), si_m, a5_bits[i]);
            @(negedge clk);
        end
        chk("a5_latch_cycle9", latch_m, 1);
        chk("a5_frame_cnt", cnt_m, 1);
        @(negedge clk);
        chk("a5_idle_ready", in_ready_m, 1);
        chk("a5_idle_busy", busy_m, 0);

        // 8'h01 LSB first with GAP=3
        issue(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb01_bit%0d", i), si_l, (i == 0) ? 1 : 0);
            @(negedge clk);
        end
        chk("lsb01_latch", latch_l, 1);
        chk("lsb01_frame_cnt", cnt_l, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("gap%0d_busy", i), busy_l, 1);
            chk($sformatf("gap%0d_si", i), si_l, 0);
            chk($sformatf("gap%0d_ready", i), in_ready_l, SKID);
        end
        @(negedge clk);
        chk("after_gap_busy", busy_l, 0);
        chk("after_gap_ready", in_ready_l, 1);

        // Back-to-back with in_valid held
        lat_m.delete();
        issue(1'b0, 8'h3C, 1'b1);
        issue(1'b0, 8'hC3, 1'b0);
        wait_lat(2, 40);
        if (lat_m.size() >= 2) chk("b2b_latch_spacing", lat_m[1] - lat_m[0], PERIOD_M);
        @(negedge clk);
        chk("b2b_frame_cnt", cnt_m, 3);

        // Reset on the 4th SHIFT cycle aborts the frame
        lat_m.delete();
        issue(1'b0, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_si_before", si_m, 1);
        rst = 1'b0;
        #1;
        chk("abort_si", si_m, 0);
        chk("abort_latch", latch_m, 0);
        chk("abort_busy", busy_m, 0);
        chk("abort_in_ready", in_ready_m, 0);
        q_m.delete();
        q_l.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_latch", lat_m.size(), 0);
        chk("abort_frame_cnt", cnt_m, 0);

        // Counter wrap 0xFFFF -> 0
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        @(negedge clk);
        issue(1'b0, 8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        chk("wrap_latch", latch_m, 1);
        chk("wrap_frame_cnt", cnt_m, 0);
        @(negedge clk);

        // Four-word stream
        lat_m.delete();
        issue(1'b0, 8'h11, 1'b1);
        issue(1'b0, 8'h22, 1'b1);
        issue(1'b0, 8'h44, 1'b1);
        issue(1'b0, 8'h88, 1'b0);
        wait_lat(4, 80);
        if (lat_m.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("stream_spacing%0d", i), lat_m[i] - lat_m[i-1], PERIOD_M);
        end
        @(negedge clk);
        chk("stream_frame_cnt", cnt_m, 4);

        repeat (5) @(negedge clk);
        chk("scoreboard_m_drained", q_m.size(), 0);
        chk("scoreboard_l_drained", q_l.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
